// File: rtl/matrix_3x3_window_gen.sv
// 3x3 sliding-window generator over a raster stream, using two external line FIFOs for rows r-1 and r-2.
// Define MATRIX_OUT_REG_EN to add one output register stage (window latency t+3 instead of t+2).
module matrix_3x3_window_gen #(
  parameter int P_DATA_WIDTH = 8,
  parameter int P_IMG_WIDTH  = 640,
  parameter int P_IMG_HEIGHT = 512
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_pix_valid,
  input  logic [P_DATA_WIDTH-1:0]   i_pix_data,
  output logic                      o_fifo1_wr_en,
  output logic [P_DATA_WIDTH-1:0]   o_fifo1_din,
  output logic                      o_fifo1_rd_en,
  input  logic [P_DATA_WIDTH-1:0]   i_fifo1_dout,
  input  logic                      i_fifo1_full,
  input  logic                      i_fifo1_empty,
  output logic                      o_fifo2_wr_en,
  output logic [P_DATA_WIDTH-1:0]   o_fifo2_din,
  output logic                      o_fifo2_rd_en,
  input  logic [P_DATA_WIDTH-1:0]   i_fifo2_dout,
  input  logic                      i_fifo2_full,
  input  logic                      i_fifo2_empty,
  output logic                      o_win_valid,
  output logic [9*P_DATA_WIDTH-1:0] o_win,
  output logic                      o_eof,
  output logic                      o_err
);

  localparam int DW = P_DATA_WIDTH;
  localparam int CW = $clog2(P_IMG_WIDTH);
  localparam int RW = $clog2(P_IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST   = CW'(P_IMG_WIDTH - 1);
  localparam logic [CW-1:0] COL_TWO    = CW'(2);
  localparam logic [RW-1:0] ROW_LAST   = RW'(P_IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_PENULT = RW'(P_IMG_HEIGHT - 2);
  localparam logic [RW-1:0] ROW_ONE    = RW'(1);
  localparam logic [RW-1:0] ROW_TWO    = RW'(2);

  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic          s1_vld;
  logic [DW-1:0] s1_pix;
  logic [CW-1:0] s1_col;
  logic [RW-1:0] s1_row;

  logic [2:0][2:0][DW-1:0] sr;
  logic [2:0][DW-1:0]      new_col;
  logic [9*DW-1:0]         win_next;
  logic                    win_hit;
  logic                    eof_hit;
  logic                    err_evt;

  logic                    win_vld_q;
  logic [9*DW-1:0]         win_q;
  logic                    eof_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      col <= '0;
      row <= '0;
    end else if (i_pix_valid) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  // Reads issue with the pixel so FIFO dout lines up with the S1 pixel one cycle later.
  assign o_fifo1_rd_en = i_rst_n & i_pix_valid & (row >= ROW_ONE);
  assign o_fifo2_rd_en = i_rst_n & i_pix_valid & (row >= ROW_TWO);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1_vld <= 1'b0;
      s1_pix <= '0;
      s1_col <= '0;
      s1_row <= '0;
    end else begin
      s1_vld <= i_pix_valid;
      if (i_pix_valid) begin
        s1_pix <= i_pix_data;
        s1_col <= col;
        s1_row <= row;
      end
    end
  end

  // The last row is never written, leaving both FIFOs drained at frame end.
  assign o_fifo1_wr_en = i_rst_n & s1_vld & (s1_row <= ROW_PENULT);
  assign o_fifo1_din   = s1_pix;
  assign o_fifo2_wr_en = i_rst_n & s1_vld & (s1_row >= ROW_ONE) & (s1_row <= ROW_PENULT);
  assign o_fifo2_din   = i_fifo1_dout;

  assign new_col[0] = i_fifo2_dout;
  assign new_col[1] = i_fifo1_dout;
  assign new_col[2] = s1_pix;

  always_comb begin
    win_next = '0;
    for (int r = 0; r < 3; r++) begin
      win_next[(3*r+0)*DW +: DW] = sr[r][1];
      win_next[(3*r+1)*DW +: DW] = sr[r][2];
      win_next[(3*r+2)*DW +: DW] = new_col[r];
    end
  end

  assign win_hit = s1_vld & (s1_row >= ROW_TWO) & (s1_col >= COL_TWO);
  assign eof_hit = win_hit & (s1_row == ROW_LAST) & (s1_col == COL_LAST);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sr        <= '0;
      win_vld_q <= 1'b0;
      win_q     <= '0;
      eof_q     <= 1'b0;
    end else begin
      if (s1_vld) begin
        for (int r = 0; r < 3; r++) begin
          sr[r] <= {new_col[r], sr[r][2], sr[r][1]};
        end
      end
      win_vld_q <= win_hit;
      eof_q     <= eof_hit;
      if (win_hit) begin
        win_q <= win_next;
      end
    end
  end

  assign err_evt = (o_fifo1_rd_en & i_fifo1_empty) | (o_fifo2_rd_en & i_fifo2_empty) |
                   (o_fifo1_wr_en & i_fifo1_full)  | (o_fifo2_wr_en & i_fifo2_full);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_err <= 1'b0;
    end else if (err_evt) begin
      o_err <= 1'b1;
    end
  end

`ifdef MATRIX_OUT_REG_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_win_valid <= 1'b0;
      o_win       <= '0;
      o_eof       <= 1'b0;
    end else begin
      o_win_valid <= win_vld_q;
      o_win       <= win_q;
      o_eof       <= eof_q;
    end
  end
`else
  assign o_win_valid = win_vld_q;
  assign o_win       = win_q;
  assign o_eof       = eof_q;
`endif

endmodule

// File: tb/tb_matrix_3x3_window_gen.sv
// Bench for matrix_3x3_window_gen: queue-based line FIFO models, frame-array reference windows, arrival-cycle scoreboard.
module tb_matrix_3x3_window_gen;

  localparam int DW    = 8;
  localparam int W     = 4;
  localparam int H     = 4;
  localparam int DEPTH = 8;
`ifdef MATRIX_OUT_REG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            pix_valid = 1'b0;
  logic [DW-1:0]   pix_data = '0;
  logic            wr1, rd1, wr2, rd2;
  logic [DW-1:0]   din1, din2;
  logic [DW-1:0]   dout1 = '0, dout2 = '0;
  logic            e1 = 1'b1, e2 = 1'b1, f1 = 1'b0, f2 = 1'b0;
  logic            force_e1 = 1'b0;
  logic            fifo1_empty;
  logic            win_vld, eof, err;
  logic [9*DW-1:0] win;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int t34 = 0;

  logic [DW-1:0]   q1[$], q2[$];
  logic [DW-1:0]   frame [H][W];
  logic [9*DW-1:0] exp_w[$];
  int              exp_c[$];
  logic            exp_e[$];
  logic [9*DW-1:0] got_w[$];
  int              got_c[$];

  localparam logic [9*DW-1:0] FIRST_WIN = 72'h22_21_20_12_11_10_02_01_00;

  assign fifo1_empty = e1 | force_e1;

  matrix_3x3_window_gen #(.P_DATA_WIDTH(DW), .P_IMG_WIDTH(W), .P_IMG_HEIGHT(H)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_valid(pix_valid), .i_pix_data(pix_data),
    .o_fifo1_wr_en(wr1), .o_fifo1_din(din1), .o_fifo1_rd_en(rd1),
    .i_fifo1_dout(dout1), .i_fifo1_full(f1), .i_fifo1_empty(fifo1_empty),
    .o_fifo2_wr_en(wr2), .o_fifo2_din(din2), .o_fifo2_rd_en(rd2),
    .i_fifo2_dout(dout2), .i_fifo2_full(f2), .i_fifo2_empty(e2),
    .o_win_valid(win_vld), .o_win(win), .o_eof(eof), .o_err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Standard-mode line FIFOs: dout registered on rd_en, flags registered.
  always @(posedge clk) begin
    if (!rst_n) begin
      q1.delete(); q2.delete();
      dout1 <= '0; dout2 <= '0;
      e1 <= 1'b1; e2 <= 1'b1; f1 <= 1'b0; f2 <= 1'b0;
    end else begin
      if (rd1 && q1.size() > 0) dout1 <= q1.pop_front();
      if (wr1 && q1.size() < DEPTH) q1.push_back(din1);
      if (rd2 && q2.size() > 0) dout2 <= q2.pop_front();
      if (wr2 && q2.size() < DEPTH) q2.push_back(din2);
      e1 <= (q1.size() == 0); f1 <= (q1.size() >= DEPTH);
      e2 <= (q2.size() == 0); f2 <= (q2.size() >= DEPTH);
    end
  end

  // Scoreboard: every strobe must match the next expected window, its eof flag and arrival cycle.
  always @(negedge clk) begin
    if (win_vld) begin
      got_w.push_back(win);
      got_c.push_back(cyc);
      checks++;
      if (exp_w.size() == 0) begin
        failures++;
        $display("FAIL unexpected_window cycle=%0d win=%h", cyc, win);
      end else begin
        if (win !== exp_w[0] || eof !== exp_e[0] || cyc !== exp_c[0]) begin
          failures++;
          $display("FAIL window got=%h eof=%b cycle=%0d required=%h eof=%b cycle=%0d",
                   win, eof, cyc, exp_w[0], exp_e[0], exp_c[0]);
        end
        void'(exp_w.pop_front()); void'(exp_e.pop_front()); void'(exp_c.pop_front());
      end
    end
  end

  function automatic logic [9*DW-1:0] ref_window(input int r, input int c);
    logic [9*DW-1:0] w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(3*i+j)*DW +: DW] = frame[r-2+i][c-2+j];
    return w;
  endfunction

  task automatic send_frame(input int max_gap, input bit rnd, input int force_row, input int npix);
    int k = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (k < npix) begin
          if (max_gap > 0) begin
            repeat ($urandom_range(1, max_gap)) begin
              @(posedge clk); #1;
              pix_valid = 1'b0;
            end
          end
          @(posedge clk); #1;
          pix_valid = 1'b1;
          pix_data  = rnd ? DW'($urandom) : DW'(r*16 + c);
          force_e1  = (r == force_row);
          frame[r][c] = pix_data;
          if (r == 2 && c == 2) t34 = cyc;
          if (r >= 2 && c >= 2) begin
            exp_w.push_back(ref_window(r, c));
            exp_c.push_back(cyc + LAT);
            exp_e.push_back(r == H-1 && c == W-1);
          end
        end
        k++;
      end
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
    force_e1  = 1'b0;
  endtask

  task automatic settle();
    repeat (LAT + 4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pix_valid = 1'b1;
    pix_data = DW'($urandom);
    repeat (3) @(negedge clk);
    checks++;
    if ({win_vld, eof, err, rd1, rd2, wr1, wr2, win} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got vld=%b eof=%b err=%b rd=%b%b wr=%b%b win=%h required all zero",
               win_vld, eof, err, rd1, rd2, wr1, wr2, win);
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_full_frame();
    got_w.delete(); got_c.delete();
    send_frame(0, 1'b0, -1, W*H);
    settle();
    checks++;
    if (got_w.size() != 4 || exp_w.size() != 0) begin
      failures++;
      $display("FAIL full_frame_count got=%0d pending=%0d required=4/0", got_w.size(), exp_w.size());
    end
    if (got_w.size() > 0) begin
      checks++;
      if (got_w[0] !== FIRST_WIN) begin
        failures++;
        $display("FAIL first_window got=%h required=%h", got_w[0], FIRST_WIN);
      end
      checks++;
      if (got_c[0] - t34 != LAT) begin
        failures++;
        $display("FAIL first_latency got=%0d required=%0d", got_c[0] - t34, LAT);
      end
    end
    checks++;
    if (win[8*DW +: DW] !== 8'd51) begin
      failures++;
      $display("FAIL last_p22 got=%0d required=51", win[8*DW +: DW]);
    end
    checks++;
    if ({e1, e2, err} !== 3'b110) begin
      failures++;
      $display("FAIL frame_end_state empty1=%b empty2=%b err=%b required 1 1 0", e1, e2, err);
    end
  endtask

  task automatic test_back_to_back();
    got_w.delete(); got_c.delete();
    send_frame(0, 1'b0, -1, W*H);
    send_frame(0, 1'b1, -1, W*H);
    settle();
    checks++;
    if (got_w.size() != 8 || exp_w.size() != 0 || err !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back got=%0d pending=%0d err=%b required 8/0/0", got_w.size(), exp_w.size(), err);
    end
  endtask

  task automatic test_gaps();
    got_w.delete(); got_c.delete();
    send_frame(3, 1'b0, -1, W*H);
    send_frame(3, 1'b1, -1, W*H);
    settle();
    checks++;
    if (got_w.size() != 8 || exp_w.size() != 0) begin
      failures++;
      $display("FAIL gaps_count got=%0d pending=%0d required 8/0", got_w.size(), exp_w.size());
    end
    checks++;
    if (got_w.size() > 0 && got_w[0] !== FIRST_WIN) begin
      failures++;
      $display("FAIL gaps_first_window got=%h required=%h", got_w[0], FIRST_WIN);
    end
  endtask

  task automatic test_underflow();
    send_frame(0, 1'b1, 1, W*H);
    settle();
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_set got=%b required=1", err);
    end
    repeat (10) @(negedge clk);
    checks++;
    if (err !== 1'b1) begin
      failures++;
      $display("FAIL err_sticky got=%b required=1", err);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      failures++;
      $display("FAIL err_cleared got=%b required=0", err);
    end
  endtask

  task automatic test_mid_reset();
    got_w.delete(); got_c.delete();
    send_frame(0, 1'b1, -1, 2*W + 2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_frame(0, 1'b0, -1, W*H);
    settle();
    checks++;
    if (got_w.size() != 4 || exp_w.size() != 0) begin
      failures++;
      $display("FAIL mid_reset_count got=%0d pending=%0d required 4/0", got_w.size(), exp_w.size());
    end
    if (got_c.size() > 0) begin
      checks++;
      if (got_w[0] !== FIRST_WIN || got_c[0] - t34 != LAT) begin
        failures++;
        $display("FAIL mid_reset_first got=%h lat=%0d required=%h lat=%0d",
                 got_w[0], got_c[0] - t34, FIRST_WIN, LAT);
      end
    end
    checks++;
    if ({e1, e2, err} !== 3'b110) begin
      failures++;
      $display("FAIL mid_reset_end_state empty1=%b empty2=%b err=%b required 1 1 0", e1, e2, err);
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_back_to_back();
    test_gaps();
    test_underflow();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
